// File: rtl/program_result_monitor_pkg.sv
// Shared types for the program result monitor: verdict encoding and a
// helper that classifies a verdict as terminal.
package result_monitor_pkg;

    localparam int STATUS_WIDTH = 3;

    typedef enum logic [STATUS_WIDTH-1:0] {
        ARMED     = 3'd0,
        RUN       = 3'd1,
        PASS      = 3'd2,
        FAIL      = 3'd3,
        EXHAUSTED = 3'd4,
        TIMEOUT   = 3'd5
    } status_t;

    // A verdict is terminal once the run has ended for any reason.
    function automatic logic is_terminal(input logic [STATUS_WIDTH-1:0] s);
        return (s == PASS) || (s == FAIL) || (s == EXHAUSTED) || (s == TIMEOUT);
    endfunction

endpackage

// File: rtl/program_result_monitor_if.sv
// Data-memory store port and instruction-exhaustion flag as seen by the
// result monitor. The core side drives (master), the monitor observes (slave).
interface program_result_monitor_if #(
    parameter int BIT_COUNT  = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_en;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_adr;
    logic [BIT_COUNT-1:0]  mem_write_data;
    logic                  instr_exhausted;

    modport master (
        output mem_en, mem_write, mem_adr, mem_write_data, instr_exhausted
    );

    modport slave (
        input mem_en, mem_write, mem_adr, mem_write_data, instr_exhausted
    );
endinterface

// File: rtl/program_result_monitor_cycle_watchdog.sv
// Saturating cycle counter with an expiry flag raised while the count
// sits at TIMEOUT_CYCLES-1, i.e. in the last cycle allowed in RUN.
module cycle_watchdog #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] count_reg;

    // Count enabled cycles; hold at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count   = count_reg;
    assign expired = (count_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/program_result_monitor.sv
// End-of-program checker: watches stores to RESULT_ADDR, compares them in
// order against the packed expected vector and reports a sticky verdict.
// Optional simulation hook: define RESULT_MONITOR_STOP_EN to print the
// verdict and $stop on entry to any terminal state.
module program_result_monitor
    import result_monitor_pkg::*;
#(
    parameter int                    BIT_COUNT      = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    NUM_CHECKS     = 4,
    parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR    = 'hC,
    parameter int                    TIMEOUT_CYCLES = 100000,
    parameter int                    CNT_WIDTH      = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    program_result_monitor_if.slave            bus,
    input  logic [NUM_CHECKS*BIT_COUNT-1:0]    expected,
    output status_t                            status,
    output logic                               done,
    output logic [$clog2(NUM_CHECKS+1)-1:0]    check_index,
    output logic [BIT_COUNT-1:0]               bad_value,
    output logic [CNT_WIDTH-1:0]               cycle_count
);

    localparam int IDX_W = $clog2(NUM_CHECKS + 1);
    localparam int SLOTS = 2 ** IDX_W;

    localparam logic [STATUS_WIDTH-1:0] S_ARMED     = ARMED;
    localparam logic [STATUS_WIDTH-1:0] S_RUN       = RUN;
    localparam logic [STATUS_WIDTH-1:0] S_PASS      = PASS;
    localparam logic [STATUS_WIDTH-1:0] S_FAIL      = FAIL;
    localparam logic [STATUS_WIDTH-1:0] S_EXHAUSTED = EXHAUSTED;
    localparam logic [STATUS_WIDTH-1:0] S_TIMEOUT   = TIMEOUT;

    logic [STATUS_WIDTH-1:0] state_reg, state_next;
    logic [IDX_W-1:0]        index_reg, index_next, index_plus;
    logic [BIT_COUNT-1:0]    bad_reg, bad_next;
    logic                    done_reg;
    logic                    store_hit, data_match, expired, wd_en, wd_clr;

    // Expected values unpacked into a power-of-two table so the running
    // index can address it directly; unused slots read as zero.
    logic [BIT_COUNT-1:0] exp_slot [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_CHECKS) begin : g_used
                assign exp_slot[gi] = expected[gi*BIT_COUNT +: BIT_COUNT];
            end else begin : g_pad
                assign exp_slot[gi] = '0;
            end
        end
    endgenerate

    assign store_hit  = bus.mem_en & bus.mem_write & (bus.mem_adr == RESULT_ADDR);
    assign data_match = (bus.mem_write_data == exp_slot[index_reg]);
    assign index_plus = index_reg + 1'b1;

    // Verdict FSM: a qualifying store outranks exhaustion, which outranks timeout.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        bad_next   = bad_reg;
        case (state_reg)
            S_ARMED: state_next = S_RUN;
            S_RUN: begin
                if (store_hit) begin
                    if (data_match) begin
                        index_next = index_plus;
                        if (index_plus == IDX_W'(NUM_CHECKS)) begin
                            state_next = S_PASS;
                        end
                    end else begin
                        bad_next   = bus.mem_write_data;
                        state_next = S_FAIL;
                    end
                end else if (bus.instr_exhausted) begin
                    state_next = S_EXHAUSTED;
                end else if (expired) begin
                    state_next = S_TIMEOUT;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    // The counter only advances on cycles that stay in RUN, so it freezes
    // at the value it held in the cycle that produced the verdict.
    assign wd_en  = (state_reg == S_RUN) && (state_next == S_RUN);
    assign wd_clr = (state_reg == S_ARMED);

    cycle_watchdog #(
        .CNT_WIDTH      (CNT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .en      (wd_en),
        .clr     (wd_clr),
        .count   (cycle_count),
        .expired (expired)
    );

    // Verdict state and observation registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_ARMED;
            index_reg <= '0;
            bad_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            bad_reg   <= bad_next;
            done_reg  <= is_terminal(state_next);
        end
    end

    assign status      = status_t'(state_reg);
    assign done        = done_reg;
    assign check_index = index_reg;
    assign bad_value   = bad_reg;

`ifdef RESULT_MONITOR_STOP_EN
    // Simulation aid: report the verdict once and halt.
    always @(posedge clk) begin
        if (reset && (state_reg == S_RUN) && is_terminal(state_next)) begin
            if (state_next == S_FAIL) begin
                $display("[result_monitor] verdict=%0d check_index=%0d bad_value=%0h cycle_count=%0d",
                         state_next, index_next, bad_next, cycle_count);
            end else begin
                $display("[result_monitor] verdict=%0d check_index=%0d cycle_count=%0d",
                         state_next, index_next, cycle_count);
            end
            $stop;
        end
    end
`endif

endmodule

// File: tb/tb_program_result_monitor.sv
// Bench for program_result_monitor: a 3-check / 50-cycle-timeout instance
// driven from a vector table, plus a 1-check instance and hand-written
// sequences for stickiness and asynchronous reset.
module tb_program_result_monitor;
    import result_monitor_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    program_result_monitor_if #(.BIT_COUNT(32), .ADDR_WIDTH(32)) bus_a ();
    program_result_monitor_if #(.BIT_COUNT(32), .ADDR_WIDTH(32)) bus_b ();

    logic [31:0] exp_a;
    logic [95:0] exp_b;
    status_t     status_a, status_b;
    logic        done_a, done_b;
    logic [0:0]  idx_a;
    logic [1:0]  idx_b;
    logic [31:0] bad_a, bad_b, cnt_a, cnt_b;

    program_result_monitor #(.NUM_CHECKS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .expected(exp_a),
        .status(status_a), .done(done_a), .check_index(idx_a),
        .bad_value(bad_a), .cycle_count(cnt_a)
    );

    program_result_monitor #(.NUM_CHECKS(3), .TIMEOUT_CYCLES(50)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .expected(exp_b),
        .status(status_b), .done(done_b), .check_index(idx_b),
        .bad_value(bad_b), .cycle_count(cnt_b)
    );

    typedef struct {
        logic [63:0] st;
        logic [63:0] idx;
        logic [63:0] bad;
        logic [63:0] cnt;
        logic [63:0] dn;
    } exp_t;

    typedef struct {
        int          n_pre;   // matching stores 1..n_pre in cycles 1..n_pre
        int          ev_cyc;  // cycle of the event under test
        logic        en;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] data;
        logic        exh;
        status_t     st;
        int          idx;
        logic [31:0] bad;
        int          cnt;
        logic        dn;
    } vec_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic idle_all();
        bus_a.mem_en = 0; bus_a.mem_write = 0; bus_a.mem_adr = 0;
        bus_a.mem_write_data = 0; bus_a.instr_exhausted = 0;
        bus_b.mem_en = 0; bus_b.mem_write = 0; bus_b.mem_adr = 0;
        bus_b.mem_write_data = 0; bus_b.instr_exhausted = 0;
    endtask

    task automatic store_b(input logic [31:0] adr, input logic [31:0] data);
        bus_b.mem_en = 1; bus_b.mem_write = 1;
        bus_b.mem_adr = adr; bus_b.mem_write_data = data;
    endtask

    // Holds reset for two cycles, releases it, and returns at the falling
    // edge after the ARMED->RUN edge (cycle 0 of RUN).
    task automatic do_reset();
        reset = 1'b0;
        idle_all();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_exp(input status_t st, input int idx, input logic [31:0] bad,
                            input int cnt, input logic dn);
        exp_t e;
        e.st = 64'(st); e.idx = 64'(idx); e.bad = 64'(bad); e.cnt = 64'(cnt); e.dn = 64'(dn);
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp_b(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_status"}, 64'(status_b), e.st);
            chk({tag, "_idx"},    64'(idx_b),    e.idx);
            chk({tag, "_bad"},    64'(bad_b),    e.bad);
            chk({tag, "_cnt"},    64'(cnt_b),    e.cnt);
            chk({tag, "_done"},   64'(done_b),   e.dn);
            $display("[TB] %s status=%0d idx=%0d bad=%0h cnt=%0d done=%0d",
                     tag, status_b, idx_b, bad_b, cnt_b, done_b);
        end
    endtask

    task automatic wait_done_b(input string tag);
        int k = 0;
        while (!done_b && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done_b) chk({tag, "_done_wait"}, 64'(done_b), 64'd1);
    endtask

    vec_t vecs[15];

    initial begin
        exp_a = 32'h0000_000f;
        exp_b = {32'd3, 32'd2, 32'd1};
        idle_all();

        vecs[0]  = '{2, 10, 1, 1, 32'hC,         32'd7, 0, FAIL,      2, 32'd7, 10, 1};
        vecs[1]  = '{2,  5, 1, 1, 32'hC,         32'd3, 0, PASS,      3, 32'd0,  5, 1};
        vecs[2]  = '{0,  4, 1, 1, 32'h8,         32'd1, 0, RUN,       0, 32'd0,  5, 0};
        vecs[3]  = '{0,  4, 1, 0, 32'hC,         32'd1, 0, RUN,       0, 32'd0,  5, 0};
        vecs[4]  = '{0,  4, 0, 1, 32'hC,         32'd1, 0, RUN,       0, 32'd0,  5, 0};
        vecs[5]  = '{0, 10, 0, 0, 32'h0,         32'd0, 1, EXHAUSTED, 0, 32'd0, 10, 1};
        vecs[6]  = '{0, 10, 1, 1, 32'hC,         32'd9, 1, FAIL,      0, 32'd9, 10, 1};
        vecs[7]  = '{0, 10, 1, 1, 32'h8,         32'd1, 1, EXHAUSTED, 0, 32'd0, 10, 1};
        vecs[8]  = '{0,  0, 0, 0, 32'h0,         32'd0, 0, TIMEOUT,   0, 32'd0, 49, 1};
        vecs[9]  = '{2, 49, 1, 1, 32'hC,         32'd3, 0, PASS,      3, 32'd0, 49, 1};
        vecs[10] = '{2, 49, 1, 1, 32'hC,         32'd4, 0, FAIL,      2, 32'd4, 49, 1};
        vecs[11] = '{0, 49, 0, 0, 32'h0,         32'd0, 1, EXHAUSTED, 0, 32'd0, 49, 1};
        vecs[12] = '{0,  4, 1, 1, 32'h8000_000C, 32'd1, 0, RUN,       0, 32'd0,  5, 0};
        vecs[13] = '{1,  3, 1, 1, 32'hC,         32'd5, 0, FAIL,      1, 32'd5,  3, 1};
        vecs[14] = '{3, 10, 0, 0, 32'h0,         32'd0, 0, PASS,      3, 32'd0,  3, 1};

        // Reset state of both instances.
        #1 reset = 1'b0;
        #3;
        chk("rst_status_a", 64'(status_a), 64'(ARMED));
        chk("rst_done_a",   64'(done_a),   64'd0);
        chk("rst_status_b", 64'(status_b), 64'(ARMED));
        chk("rst_idx_b",    64'(idx_b),    64'd0);
        chk("rst_bad_b",    64'(bad_b),    64'd0);
        chk("rst_cnt_b",    64'(cnt_b),    64'd0);

        // Table-driven scenarios on the 3-check instance.
        foreach (vecs[v]) begin
            do_reset();
            for (int c = 0; c <= vecs[v].ev_cyc; c++) begin
                idle_all();
                if (c >= 1 && c <= vecs[v].n_pre) store_b(32'hC, 32'(c));
                if (c == vecs[v].ev_cyc) begin
                    if (vecs[v].en || vecs[v].wr) begin
                        bus_b.mem_en = vecs[v].en; bus_b.mem_write = vecs[v].wr;
                        bus_b.mem_adr = vecs[v].adr; bus_b.mem_write_data = vecs[v].data;
                    end
                    if (vecs[v].exh) bus_b.instr_exhausted = 1'b1;
                    push_exp(vecs[v].st, vecs[v].idx, vecs[v].bad, vecs[v].cnt, vecs[v].dn);
                end
                @(negedge clk);
            end
            idle_all();
            if (vecs[v].dn) wait_done_b($sformatf("vec%0d", v));
            pop_cmp_b($sformatf("vec%0d", v));
        end

        // Single-check instance: final store in cycle 20.
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            idle_all();
            if (c == 20) begin
                bus_a.mem_en = 1; bus_a.mem_write = 1;
                bus_a.mem_adr = 32'hC; bus_a.mem_write_data = 32'h0f;
            end
            @(negedge clk);
        end
        idle_all();
        begin
            int k = 0;
            while (!done_a && k < 200) begin @(negedge clk); k++; end
        end
        repeat (3) @(negedge clk);
        chk("a_status", 64'(status_a), 64'(PASS));
        chk("a_done",   64'(done_a),   64'd1);
        chk("a_idx",    64'(idx_a),    64'd1);
        chk("a_cnt",    64'(cnt_a),    64'd20);
        chk("a_bad",    64'(bad_a),    64'd0);
        $display("[TB] single status=%0d idx=%0d cnt=%0d", status_a, idx_a, cnt_a);

        // Sticky verdict: a later correct store must not disturb FAIL.
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            idle_all();
            if (c == 1) store_b(32'hC, 32'd1);
            if (c == 2) store_b(32'hC, 32'd2);
            if (c == 3) begin store_b(32'hC, 32'd7); push_exp(FAIL, 2, 32'd7, 3, 1); end
            if (c == 6) store_b(32'hC, 32'd3);
            @(negedge clk);
        end
        idle_all();
        pop_cmp_b("sticky");

        // Asynchronous reset mid-run, then a clean rerun.
        do_reset();
        for (int c = 0; c <= 2; c++) begin
            idle_all();
            if (c == 1) store_b(32'hC, 32'd1);
            @(negedge clk);
        end
        idle_all();
        chk("mid_idx_before", 64'(idx_b), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_status", 64'(status_b), 64'(ARMED));
        chk("mid_idx",    64'(idx_b),    64'd0);
        chk("mid_cnt",    64'(cnt_b),    64'd0);
        chk("mid_done",   64'(done_b),   64'd0);
        $display("[TB] async_reset status=%0d idx=%0d cnt=%0d", status_b, idx_b, cnt_b);
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            idle_all();
            if (c >= 1) store_b(32'hC, 32'(c));
            if (c == 3) push_exp(PASS, 3, 32'd0, 3, 1);
            @(negedge clk);
        end
        idle_all();
        pop_cmp_b("rerun");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_result_monitor.md
Name: program_result_monitor

Overview:
- Synthesisable, parametrised end-of-program checker attached to the core's data-memory write port.
- Compares an ordered sequence of NUM_CHECKS result stores to RESULT_ADDR against an expected-value vector.
- Detects instruction exhaustion and a cycle watchdog timeout, and reports a sticky verdict.
- Sits beside doubleMemoryCore in benches and in FPGA builds as a self-test status source.

Parameters:
- BIT_COUNT, 32, data width of the store bus and expected values.
- ADDR_WIDTH, 32, memory address width.
- NUM_CHECKS, 4, number of ordered result stores required for PASS (≥1).
- RESULT_ADDR, 32'hC, address whose stores are checked.
- TIMEOUT_CYCLES, 100000, maximum cycles in RUN before TIMEOUT (≥1).
- CNT_WIDTH, 32, cycle-counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_en  in  1  data-memory access enable.
- mem_write  in  1  access is a store.
- mem_adr  in  ADDR_WIDTH  store address.
- mem_write_data  in  BIT_COUNT  store data.
- instr_exhausted  in  1  instruction memory returned an unknown/past-end word this cycle.
- expected  in  NUM_CHECKS*BIT_COUNT  packed expected values; check k uses slice k.
- status  out  3  status_t verdict.
- done  out  1  status is terminal.
- check_index  out  $clog2(NUM_CHECKS+1)  number of matched stores so far.
- bad_value  out  BIT_COUNT  data of the mismatching store.
- cycle_count  out  CNT_WIDTH  cycles spent in RUN, frozen at terminal.

Behaviour:
- Reset (reset==0, async): status=ARMED, done=0, check_index=0, bad_value=0, cycle_count=0.
- States (status_t):
  - ARMED: entered on reset. Goes to RUN on the first rising edge after reset deasserts. No checks are made in ARMED.
  - RUN: cycle_count increments each cycle. A qualifying store is mem_en & mem_write & (mem_adr==RESULT_ADDR).
    - Qualifying store whose data equals expected[check_index]: check_index+1. If the new index equals NUM_CHECKS, go to PASS.
    - Qualifying store whose data does not match: latch bad_value; go to FAIL. check_index holds the failing slot.
    - Else if instr_exhausted=1: go to EXHAUSTED.
    - Else if cycle_count reaches TIMEOUT_CYCLES-1: go to TIMEOUT.
  - PASS, FAIL, EXHAUSTED, TIMEOUT: terminal and sticky until reset. done=1. All other outputs frozen. Later stores are ignored.
- Priority when events coincide in one cycle: store evaluation > instr_exhausted > timeout. Examples:
  - A matching final store coinciding with timeout gives PASS.
  - A mismatch coinciding with exhaustion gives FAIL.
- Non-qualifying stores and loads are ignored. Address compare uses the full ADDR_WIDTH.
- Registered outputs: the verdict is visible the cycle after the triggering edge.
- Reset asserted mid-RUN or in a terminal state: immediate return to reset values. The next run re-arms.
- cycle_count saturates and never wraps; timeout always fires first because TIMEOUT_CYCLES fits in CNT_WIDTH.
- expected may change only while done=1 or during reset.

Optional Feature:
- RESULT_MONITOR_STOP_EN, simulation only.
  - Defined: on entry to any terminal state, $display the verdict, check_index, bad_value (on FAIL) and cycle_count, then $stop.
  - Undefined: no system tasks; the block is purely synthesisable with identical port behaviour.

Decomposition:
- Package result_monitor_pkg: status_t enum {ARMED, RUN, PASS, FAIL, EXHAUSTED, TIMEOUT} (3 bits) and STATUS_WIDTH=3.
- Sub-module cycle_watchdog holds the CNT_WIDTH counter, with enable, clear, saturation and an expired flag at the TIMEOUT_CYCLES-1 match. The top FSM owns comparison and the verdict.

Test Plan:
- NUM_CHECKS=1, expected=32'h0f; store 0x0f to 0xC at cycle 20 -> PASS, done=1, check_index=1, cycle_count frozen at 20.
- NUM_CHECKS=3, expected={3,2,1}; stores 1, 2, then 7 to 0xC -> FAIL, check_index=2, bad_value=7. A later store of 3 does not change the verdict.
- Stores to 0x8 and loads from 0xC with matching data -> status stays RUN, check_index=0.
- TIMEOUT_CYCLES=50 with no stores -> TIMEOUT exactly 50 cycles after entering RUN, cycle_count=49. A matching final store in cycle 49 instead gives PASS.
- instr_exhausted pulsed at cycle 10 together with a mismatching store -> FAIL. Alone -> EXHAUSTED.
- reset pulled low mid-RUN after one match -> outputs return to reset values asynchronously. The rerun passes normally.
